// File: rtl/clahe_hist_rmw.sv
// Histogram read-modify-write stage for CLAHE: increments bin {tile, pixel} in an
// external READ_FIRST RAM, bypassing the previous write, and clears all bins per frame.
module clahe_hist_rmw #(
    parameter int TILE_W = 4,
    parameter int CNT_W  = 16,
    parameter int PCNT_W = 24
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                in_valid,
    input  logic [7:0]          in_pixel,
    input  logic [TILE_W-1:0]   in_tile,
    output logic                ram_re,
    output logic [TILE_W+7:0]   ram_raddr,
    input  logic [CNT_W-1:0]    ram_rdata,
    output logic                ram_we,
    output logic [TILE_W+7:0]   ram_waddr,
    output logic [CNT_W-1:0]    ram_wdata,
    output logic                clr_busy,
    output logic                sat_flag,
    output logic [PCNT_W-1:0]   pix_cnt
);

    localparam int AW = TILE_W + 8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CLEAR,
        ST_ACCUM
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_clr_addr;
    logic                r_v1;
    logic [AW-1:0]       r_a1;
    logic                r_v2;
    logic [AW-1:0]       r_a2;
    logic [CNT_W-1:0]    r_d2;
    logic                r_sat;
    logic [PCNT_W-1:0]   r_pix_cnt;

    logic                w_accept;
    logic [AW-1:0]       w_raddr;
    logic [CNT_W-1:0]    w_old;
    logic [CNT_W-1:0]    w_new;
    logic                w_sat_hit;

    always_comb begin
        w_raddr   = {in_tile, in_pixel};
        w_accept  = (r_state == ST_ACCUM) && in_valid && !frame_start;
        // The RAM returns pre-write data when the previous write lands on the read edge
        w_old     = (r_v2 && (r_a2 == r_a1)) ? r_d2 : ram_rdata;
        w_sat_hit = r_v1 && (w_old == '1);
        w_new     = (w_old == '1) ? w_old : w_old + CNT_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_addr == '1) w_state_nxt = ST_ACCUM;
            ST_ACCUM: w_state_nxt = ST_ACCUM;
            default:  w_state_nxt = ST_INIT;
        endcase
        if (frame_start) w_state_nxt = ST_CLEAR;
    end

    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = '0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        case (r_state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = r_clr_addr;
            end
            ST_ACCUM: begin
                ram_re    = w_accept;
                ram_raddr = w_raddr;
                ram_we    = r_v1;
                ram_waddr = r_a1;
                ram_wdata = w_new;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_clr_addr <= '0;
            r_v1       <= 1'b0;
            r_a1       <= '0;
            r_v2       <= 1'b0;
            r_a2       <= '0;
            r_d2       <= '0;
            r_sat      <= 1'b0;
            r_pix_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= (r_state == ST_CLEAR && !frame_start) ? r_clr_addr + AW'(1) : '0;
            r_v1       <= w_accept;
            r_a1       <= w_raddr;
            // A write completing in the frame_start cycle must not feed the new frame
            r_v2       <= r_v1 && !frame_start;
            r_a2       <= r_a1;
            r_d2       <= w_new;
            if (frame_start)
                r_sat <= 1'b0;
            else if (w_sat_hit)
                r_sat <= 1'b1;
            if (frame_start)
                r_pix_cnt <= '0;
            else if (w_accept && (r_pix_cnt != '1))
                r_pix_cnt <= r_pix_cnt + PCNT_W'(1);
        end
    end

    assign clr_busy = (r_state != ST_ACCUM);
    assign sat_flag = r_sat;
    assign pix_cnt  = r_pix_cnt;

endmodule
